// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces hcount/vcount, hsync/vsync, hblnk/vblnk and line/frame start
// strobes. The raster advances only when pix_en is high. Every output is a
// register loaded from a decode of the next counts, so the syncs and blanks
// line up with the counts they belong to.
module vga_timing_gen #(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

    // Counter-width constants used by the comparators.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject modes that cannot be represented or have an empty interval.
    if (64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
    end
    if (CNT_W == 0 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    // Next raster position: advance on pix_en, wrapping both counts at frame end.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d = '0;
                end else begin
                    vcount_d = vcount_q + CNT_W'(1);
                end
            end else begin
                hcount_d = hcount_q + CNT_W'(1);
            end
        end
    end

    // Decode syncs, blanks and strobes from the next position.
    always_comb begin
        hblnk_d       = (hcount_d >= H_ACT_C);
        vblnk_d       = (vcount_d >= V_ACT_C);
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (hcount_d >= HS_FIRST && hcount_d <= HS_LAST) begin
            hsync_d = HS_POL;
        end
        if (vcount_d >= VS_FIRST && vcount_d <= VS_LAST) begin
            vsync_d = VS_POL;
        end
        if (pix_en && hcount_d == '0) begin
            line_start_d  = 1'b1;
            frame_start_d = (vcount_d == '0);
        end
    end

    // Output and counter registers; synchronous reset wins over pix_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 800x600 instance (A) and a small
// active-low instance (B) whose H_TOTAL equals 2**CNT_W. The reference model
// keeps the raster as a single linear pixel index per instance.
module tb_vga_timing_gen;

    localparam int HT_A = 1056, VT_A = 628;
    localparam int HT_B = 32,   VT_B = 20;

    logic        clk;
    logic        rst_a, pen_a, rst_b, pen_b;
    logic [10:0] hcount_a, vcount_a;
    logic [4:0]  hcount_b, vcount_b;
    logic        hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a;
    logic        hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b;

    int checks = 0;
    int errors = 0;

    // Model state: linear pixel index and whether the last edge advanced.
    int p_a = 0, p_b = 0;
    bit adv_a = 0, adv_b = 0;

    // Period bookkeeping and observed sync/blank ranges.
    int cnt_line_a = 0, cnt_line_b = 0, cnt_frame_b = 0;
    int n_ls_a = 0, n_fs_b = 0;
    int hs_min_a = 9999, hs_max_a = -1, hb_min_a = 9999, hnb_max_a = -1;
    int hs_min_b = 9999, hs_max_b = -1, vs_min_b = 9999, vs_max_b = -1;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(pen_a),
        .hcount(hcount_a), .vcount(vcount_a),
        .hsync(hsync_a), .vsync(vsync_a), .hblnk(hblnk_a), .vblnk(vblnk_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CNT_W(5), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(pen_b),
        .hcount(hcount_b), .vcount(vcount_b),
        .hsync(hsync_b), .vsync(vsync_b), .hblnk(hblnk_b), .vblnk(vblnk_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the position within the frame.
    task automatic check_inst(input string nm, input int ht, input int ha, input int hfp,
                              input int hsw, input int va, input int vfp, input int vsw,
                              input bit hpol, input bit vpol, input int p, input bit adv,
                              input logic [31:0] hc, input logic [31:0] vc,
                              input logic hs, input logic vs, input logic hb,
                              input logic vb, input logic ls, input logic fs);
        int  h, v;
        bit  hs_on, vs_on;
        h     = p % ht;
        v     = p / ht;
        hs_on = (h >= ha + hfp) && (h < ha + hfp + hsw);
        vs_on = (v >= va + vfp) && (v < va + vfp + vsw);
        chk({nm, "_hcount"}, hc, 32'(h));
        chk({nm, "_vcount"}, vc, 32'(v));
        chk({nm, "_hsync"}, 32'(hs), 32'(hs_on ? hpol : !hpol));
        chk({nm, "_vsync"}, 32'(vs), 32'(vs_on ? vpol : !vpol));
        chk({nm, "_hblnk"}, 32'(hb), 32'(h >= ha));
        chk({nm, "_vblnk"}, 32'(vb), 32'(v >= va));
        chk({nm, "_line_start"}, 32'(ls), 32'(adv && h == 0));
        chk({nm, "_frame_start"}, 32'(fs), 32'(adv && p == 0));
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit ra, input bit ea, input bit rb, input bit eb);
        rst_a = ra; pen_a = ea; rst_b = rb; pen_b = eb;
        @(posedge clk);
        adv_a = !ra && ea;
        adv_b = !rb && eb;
        if (ra) p_a = 0; else if (ea) p_a = (p_a + 1) % (HT_A * VT_A);
        if (rb) p_b = 0; else if (eb) p_b = (p_b + 1) % (HT_B * VT_B);
        #1;
        check_inst("A", HT_A, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1, p_a, adv_a,
                   32'(hcount_a), 32'(vcount_a), hsync_a, vsync_a, hblnk_a, vblnk_a, ls_a, fs_a);
        check_inst("B", HT_B, 16, 4, 6, 12, 2, 3, 1'b0, 1'b0, p_b, adv_b,
                   32'(hcount_b), 32'(vcount_b), hsync_b, vsync_b, hblnk_b, vblnk_b, ls_b, fs_b);
        if (ra) cnt_line_a = 0; else if (adv_a) cnt_line_a++;
        if (rb) begin cnt_line_b = 0; cnt_frame_b = 0; end
        else if (adv_b) begin cnt_line_b++; cnt_frame_b++; end
        if (ls_a === 1'b1) begin chk("A_line_period", 32'(cnt_line_a), 32'(HT_A)); cnt_line_a = 0; n_ls_a++; end
        if (ls_b === 1'b1) begin chk("B_line_period", 32'(cnt_line_b), 32'(HT_B)); cnt_line_b = 0; end
        if (fs_b === 1'b1) begin chk("B_frame_period", 32'(cnt_frame_b), 32'(HT_B * VT_B)); cnt_frame_b = 0; n_fs_b++; end
        if (hsync_a === 1'b1) begin
            if (int'(hcount_a) < hs_min_a) hs_min_a = int'(hcount_a);
            if (int'(hcount_a) > hs_max_a) hs_max_a = int'(hcount_a);
        end
        if (hblnk_a === 1'b1 && int'(hcount_a) < hb_min_a) hb_min_a = int'(hcount_a);
        if (hblnk_a === 1'b0 && int'(hcount_a) > hnb_max_a) hnb_max_a = int'(hcount_a);
        if (hsync_b === 1'b0) begin
            if (int'(hcount_b) < hs_min_b) hs_min_b = int'(hcount_b);
            if (int'(hcount_b) > hs_max_b) hs_max_b = int'(hcount_b);
        end
        if (vsync_b === 1'b0) begin
            if (int'(vcount_b) < vs_min_b) vs_min_b = int'(vcount_b);
            if (int'(vcount_b) > vs_max_b) vs_max_b = int'(vcount_b);
        end
    endtask

    initial begin
        int v_before;

        // Reset for three clocks with pix_en high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_hcount", 32'(hcount_a), 32'd0);
        chk("rst_hsync", 32'(hsync_a), 32'd0);
        chk("rst_vsync", 32'(vsync_a), 32'd0);
        chk("rst_hsync_lowpol", 32'(hsync_b), 32'd1);
        chk("rst_strobes", 32'({ls_a, fs_a, ls_b, fs_b}), 32'd0);

        // Continuous enable for two lines of A (over three frames of B).
        n_ls_a = 0; n_fs_b = 0;
        for (int i = 0; i < 2 * HT_A + 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_line_starts", 32'(n_ls_a), 32'd2);
        chk("B_frame_starts", 32'(n_fs_b), 32'd3);
        chk("A_hsync_first", 32'(hs_min_a), 32'd840);
        chk("A_hsync_last", 32'(hs_max_a), 32'd967);
        chk("A_hblnk_first", 32'(hb_min_a), 32'd800);
        chk("A_active_last", 32'(hnb_max_a), 32'd799);

        // pix_en 1,0,0,1 around the end of a line.
        for (int i = 0; i < 2 * HT_A && (p_a % HT_A) != HT_A - 2; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_reach_1054", 32'(hcount_a), 32'd1054);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_at_1055", 32'(hcount_a), 32'd1055);
        v_before = p_a / HT_A;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            chk("A_hold_hcount", 32'(hcount_a), 32'd1055);
            chk("A_hold_no_ls", 32'(ls_a), 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_wrap_hcount", 32'(hcount_a), 32'd0);
        chk("A_wrap_vcount", 32'(vcount_a), 32'(v_before + 1));
        chk("A_wrap_ls", 32'(ls_a), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_ls_one_clk", 32'(ls_a), 32'd0);

        // Reset mid-line at hcount 512.
        for (int i = 0; i < 2 * HT_A && (p_a % HT_A) != 512; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_reach_512", 32'(hcount_a), 32'd512);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("A_midrst_h", 32'(hcount_a), 32'd0);
        chk("A_midrst_v", 32'(vcount_a), 32'd0);
        chk("A_midrst_fs", 32'(fs_a), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("A_rstexit_h", 32'(hcount_a), 32'd1);
        chk("A_rstexit_fs", 32'(fs_a), 32'd0);

        // Random enables with occasional resets.
        for (int i = 0; i < 8000; i++) begin
            step($urandom_range(1999, 0) == 0, $urandom_range(3, 0) != 0,
                 $urandom_range(1499, 0) == 0, $urandom_range(3, 0) != 0);
        end
        chk("B_hsync_first", 32'(hs_min_b), 32'd20);
        chk("B_hsync_last", 32'(hs_max_b), 32'd25);
        chk("B_vsync_first", 32'(vs_min_b), 32'd14);
        chk("B_vsync_last", 32'(vs_max_b), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
